draw_fall_ctl: RTL and testbench
================================

DRAW_FALL_CTL -- requirements
Module: draw_fall_ctl

Interface
REQ-001 Parameter list SHALL be one per line: name, default, meaning.
- POS_W, 12, coordinate width in bits.
- FLOOR_Y, 552, landing row; equals VER_PIXELS minus object height.
- PER_W, 18, step-period counter width.
- T_START, 200000, initial clocks per 1-pixel step.
- T_DEC, 250, period decrement per step while falling.
- T_MIN, 20000, period floor (terminal velocity).
- BOUNCES, 3, maximum bounces before landing (BOUNCE_EN only).

REQ-002 Port list SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, reset; asynchronous, active-high.
- mouse_left, in, 1, left button level.
- mouse_xpos, in, POS_W, pointer x.
- mouse_ypos, in, POS_W, pointer y.
- xpos, out, POS_W, object x.
- ypos, out, POS_W, object y.
- busy, out, 1, high in FALLING or RISING.
- landed, out, 1, one-cycle pulse on entry to LANDED.

Function
REQ-003 The block SHALL register mouse_left each cycle; press = mouse_left AND NOT previous sample (1-cycle pulse).
REQ-004 FSM states SHALL be IDLE, FALLING, RISING, LANDED.
REQ-005 IDLE: each cycle xpos<=mouse_xpos; ypos<=min(mouse_ypos, FLOOR_Y).
REQ-006 IDLE->FALLING on press with ypos<FLOOR_Y; load period=T_START, cnt=0, bounce_cnt=0. Press with ypos==FLOOR_Y: stay IDLE.
REQ-007 FALLING: cnt increments each cycle; when cnt==period: cnt<=0, ypos<=ypos+1, period<=max(period-T_DEC, T_MIN), all unsigned with no underflow. xpos is frozen.
REQ-008 FALLING: when ypos==FLOOR_Y the next state SHALL be LANDED, or RISING per REQ-017; ypos never exceeds FLOOR_Y.
REQ-009 RISING: same counter rule; on cnt==period: ypos<=ypos-1, period<=min(period+T_DEC, T_START).
REQ-010 RISING->FALLING when period==T_START or ypos==0, keeping the current period and zeroing cnt.
REQ-011 LANDED: xpos/ypos hold; press->IDLE. Press arriving in the same cycle as LANDED entry SHALL be ignored.
REQ-012 Presses in FALLING or RISING SHALL be ignored.
REQ-013 landed SHALL be asserted exactly one cycle, in the first cycle state==LANDED.
REQ-014 All outputs SHALL be registered; position updates appear 1 cycle after the cnt==period cycle.

Reset
REQ-015 Asserting rst (async, at any time, mid-fall included) SHALL immediately force: state=IDLE, xpos=0, ypos=0, cnt=0, period=T_START, bounce_cnt=0, mouse_prev=0, busy=0, landed=0.
REQ-016 After rst deasserts, the first IDLE tracking update SHALL occur on the next clk edge.

Configuration
REQ-017 Macro DRAW_FALL_BOUNCE_EN defined: on floor contact with bounce_cnt<BOUNCES, go to RISING, bounce_cnt++, period<=period+((T_START-period)>>1). On bounce_cnt==BOUNCES, go to LANDED.
REQ-018 Macro undefined: RISING, bounce_cnt and BOUNCES logic SHALL be absent; floor contact goes straight to LANDED.

Verification (bench params: FLOOR_Y=20, T_START=10, T_DEC=2, T_MIN=4, BOUNCES=2)
REQ-019 IDLE tracking: mouse=(100,30) -> xpos=100, ypos=20 next cycle; mouse=(5,7) -> (5,7).
REQ-020 Fall timing from y=17: steps after 11, 9 and 7 cycles; period reads 4 after 3 steps and is clamped at T_MIN thereafter; landed pulses once; busy=0.
REQ-021 Bounce (macro on), fall from y=0: first RISING entry sets period=4+((10-4)>>1)=7; exactly 2 bounces, then LANDED; ypos never exceeds 20.
REQ-022 Reset mid-FALLING at y=12 -> outputs 0 asynchronously, before the next edge; after release, tracking resumes.
REQ-023 Presses during FALLING are ignored; press in LANDED -> IDLE; press with mouse_ypos=25 (clamped to 20) keeps IDLE.
REQ-024 Macro off, same stimulus as REQ-021 -> LANDED on first contact; RISING never seen.

Source files
------------

// File: rtl/draw_fall_ctl.sv
// draw_fall_ctl: mouse-dropped object that falls under accelerating steps and lands on a floor row; optional bounce via DRAW_FALL_BOUNCE_EN
// Ports: clk, rst (async, active-high), mouse_left/mouse_xpos/mouse_ypos pointer inputs,
//        xpos/ypos object position, busy (FALLING or RISING), landed (1-cycle pulse on LANDED entry).
module draw_fall_ctl #(
  parameter int POS_W   = 12,
  parameter int FLOOR_Y = 552,
  parameter int PER_W   = 18,
  parameter int T_START = 200000,
  parameter int T_DEC   = 250,
  parameter int T_MIN   = 20000,
  parameter int BOUNCES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mouse_left,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic [POS_W-1:0] mouse_ypos,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             busy,
  output logic             landed
);
  typedef enum logic [1:0] {IDLE, FALLING, RISING, LANDED} state_t;
  localparam logic [POS_W-1:0] L_FLOOR  = POS_W'(FLOOR_Y);
  localparam logic [PER_W-1:0] L_TSTART = PER_W'(T_START);
  localparam logic [PER_W-1:0] L_TDEC   = PER_W'(T_DEC);
  localparam logic [PER_W-1:0] L_TMIN   = PER_W'(T_MIN);
  state_t           r_state, w_state;
  logic [POS_W-1:0] r_xpos, r_ypos, w_xpos, w_ypos;
  logic [PER_W-1:0] r_cnt, r_period, w_cnt, w_period, w_dec;
  logic             r_prev, r_busy, r_landed, w_press, w_tick;
  assign w_press = mouse_left & ~r_prev;
  assign w_tick  = r_cnt == r_period;
  // shrink the step period toward terminal velocity without wrapping below T_MIN
  assign w_dec   = (r_period >= L_TMIN + L_TDEC) ? r_period - L_TDEC : L_TMIN;
`ifdef DRAW_FALL_BOUNCE_EN
  localparam logic [7:0] L_BOUNCES = 8'(BOUNCES);
  logic [7:0]       r_bcnt, w_bcnt;
  logic [PER_W-1:0] w_inc, w_half;
  assign w_inc  = (r_period >= L_TSTART - L_TDEC) ? L_TSTART : r_period + L_TDEC;
  // rebound loses half of the remaining speed headroom
  assign w_half = r_period + ((L_TSTART - r_period) >> 1);
`endif
  always_comb begin
    w_state  = r_state;
    w_xpos   = r_xpos;
    w_ypos   = r_ypos;
    w_cnt    = r_cnt;
    w_period = r_period;
`ifdef DRAW_FALL_BOUNCE_EN
    w_bcnt   = r_bcnt;
`endif
    case (r_state)
      IDLE: begin
        w_xpos = mouse_xpos;
        w_ypos = (mouse_ypos > L_FLOOR) ? L_FLOOR : mouse_ypos;
        if (w_press && r_ypos < L_FLOOR) begin
          w_state  = FALLING;
          w_cnt    = '0;
          w_period = L_TSTART;
`ifdef DRAW_FALL_BOUNCE_EN
          w_bcnt   = '0;
`endif
        end
      end
      FALLING: begin
        if (r_ypos >= L_FLOOR) begin
          w_state = LANDED;
`ifdef DRAW_FALL_BOUNCE_EN
          if (r_bcnt < L_BOUNCES) begin
            w_state  = RISING;
            w_bcnt   = r_bcnt + 8'd1;
            w_period = w_half;
            w_cnt    = '0;
          end
`endif
        end else if (w_tick) begin
          w_cnt    = '0;
          w_ypos   = r_ypos + 1'b1;
          w_period = w_dec;
        end else
          w_cnt = r_cnt + 1'b1;
      end
`ifdef DRAW_FALL_BOUNCE_EN
      RISING: begin
        if (r_period == L_TSTART || r_ypos == '0) begin
          w_state = FALLING;
          w_cnt   = '0;
        end else if (w_tick) begin
          w_cnt    = '0;
          w_ypos   = r_ypos - 1'b1;
          w_period = w_inc;
        end else
          w_cnt = r_cnt + 1'b1;
      end
`endif
      // a press sampled in the landing-pulse cycle is too early to count
      LANDED: w_state = (w_press && !r_landed) ? IDLE : LANDED;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_xpos   <= '0;
      r_ypos   <= '0;
      r_cnt    <= '0;
      r_period <= L_TSTART;
      r_prev   <= 1'b0;
      r_busy   <= 1'b0;
      r_landed <= 1'b0;
`ifdef DRAW_FALL_BOUNCE_EN
      r_bcnt   <= '0;
`endif
    end else begin
      r_state  <= w_state;
      r_xpos   <= w_xpos;
      r_ypos   <= w_ypos;
      r_cnt    <= w_cnt;
      r_period <= w_period;
      r_prev   <= mouse_left;
      r_busy   <= (w_state == FALLING) || (w_state == RISING);
      r_landed <= (w_state == LANDED) && (r_state != LANDED);
`ifdef DRAW_FALL_BOUNCE_EN
      r_bcnt   <= w_bcnt;
`endif
    end
  end
  assign xpos   = r_xpos;
  assign ypos   = r_ypos;
  assign busy   = r_busy;
  assign landed = r_landed;
endmodule

// File: tb/tb_draw_fall_ctl.sv
// tb_draw_fall_ctl: directed self-checking bench for draw_fall_ctl
module tb_draw_fall_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] xpos, ypos;
  logic        busy, landed;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n, cyc, rises, maxy, p_first;
  draw_fall_ctl #(
    .POS_W(12), .FLOOR_Y(20), .PER_W(18), .T_START(10), .T_DEC(2), .T_MIN(4), .BOUNCES(2)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos), .xpos(xpos), .ypos(ypos), .busy(busy), .landed(landed)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_step(output int k);
    logic [11:0] y0;
    y0 = ypos;
    k = 0;
    while (ypos == y0 && k < 100) begin
      mouse_left = ~mouse_left;
      tick();
      k++;
    end
  endtask
  task automatic wait_land(output int c, output int r, output int my, output int pf);
    int st, pst;
    c = 0; r = 0; my = int'(ypos); pf = -1; pst = 0;
    while (landed !== 1'b1 && c < 2000) begin
      tick();
      c++;
      if (int'(ypos) > my) my = int'(ypos);
      st = int'(dut.r_state);
      if (st == 2 && pst != 2) begin
        r++;
        if (r == 1) pf = int'(dut.r_period);
      end
      pst = st;
    end
  endtask
  initial begin
    #12;
    chk("reset_xpos", xpos, 0);
    chk("reset_ypos", ypos, 0);
    chk("reset_busy", busy, 0);
    chk("reset_landed", landed, 0);
    rst = 1'b0;
    mouse_xpos = 100; mouse_ypos = 30;
    tick();
    chk("track_clamp_x", xpos, 100);
    chk("track_clamp_y", ypos, 20);
    mouse_xpos = 5; mouse_ypos = 7;
    tick();
    chk("track_x", xpos, 5);
    chk("track_y", ypos, 7);
    mouse_xpos = 9; mouse_ypos = 25;
    tick();
    chk("clamp25_y", ypos, 20);
    mouse_left = 1'b1;
    tick();
    tick();
    chk("press_at_floor_idle", busy, 0);
    mouse_left = 1'b0;
    mouse_xpos = 40; mouse_ypos = 17;
    tick();
    chk("pre_fall_y", ypos, 17);
    mouse_left = 1'b1;
    tick();
    chk("fall_busy", busy, 1);
    mouse_xpos = 77;
    wait_step(n);
    chk("step1_cycles", n, 11);
    wait_step(n);
    chk("step2_cycles", n, 9);
    wait_step(n);
    chk("step3_cycles", n, 7);
    chk("step3_y", ypos, 20);
    chk("step3_period", dut.r_period, 4);
    chk("xpos_frozen", xpos, 40);
    mouse_left = 1'b0;
    wait_land(cyc, rises, maxy, p_first);
    chk("land17_pulse", landed, 1);
`ifndef DRAW_FALL_BOUNCE_EN
    chk("land17_latency", cyc, 1);
`endif
    chk("land17_busy", busy, 0);
    mouse_ypos = 3;
    mouse_left = 1'b1;
    tick();
    chk("landed_one_cycle", landed, 0);
    chk("entry_press_ignored_y", ypos, 20);
    mouse_left = 1'b0;
    tick();
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
    chk("landed_to_idle_y", ypos, 3);
    mouse_xpos = 60; mouse_ypos = 0;
    tick();
    chk("pre_fall0_y", ypos, 0);
    mouse_left = 1'b1;
    tick();
    wait_step(n);
    chk("f0_step1", n, 11);
    wait_step(n);
    chk("f0_step2", n, 9);
    wait_step(n);
    chk("f0_step3", n, 7);
    wait_step(n);
    chk("f0_step4_clamped", n, 5);
    wait_step(n);
    chk("f0_step5_clamped", n, 5);
    mouse_left = 1'b0;
    wait_land(cyc, rises, maxy, p_first);
    chk("f0_landed", landed, 1);
    chk("f0_max_y_ok", maxy <= 20, 1);
    chk("f0_final_y", ypos, 20);
`ifdef DRAW_FALL_BOUNCE_EN
    chk("f0_bounces", rises, 2);
    chk("f0_first_rise_period", p_first, 7);
`else
    chk("f0_no_rising", rises, 0);
`endif
    tick();
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    mouse_xpos = 50; mouse_ypos = 10;
    tick();
    tick();
    chk("pre_rstfall_y", ypos, 10);
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    n = 0;
    while (ypos != 12 && n < 100) begin
      tick();
      n++;
    end
    chk("reached_y12", ypos, 12);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_x", xpos, 0);
    chk("async_rst_y", ypos, 0);
    chk("async_rst_busy", busy, 0);
    mouse_xpos = 33; mouse_ypos = 4;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_track_x", xpos, 33);
    chk("post_rst_track_y", ypos, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
